// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline hazard controller.
// State encoding and the RR/EX bubble control word.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    LDSTALL = 2'd1,
    FLUSH   = 2'd2,
    MEMWAIT = 2'd3
  } hz_state_t;

  localparam int CNT_W = 8;

  typedef struct packed {
    logic regwrite;
    logic memtoreg;
    logic memread;
    logic memwrite;
    logic alusrc;
    logic branch;
  } ex_ctrl_t;

  localparam ex_ctrl_t BUBBLE_CTRL = '0;

endpackage

// File: rtl/pipe_hazard_ctrl_sat_counter32.sv
// 32-bit event counter that sticks at all-ones.
// Used for the stall and flush performance counters.
module sat_counter32 (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  output logic [31:0] count
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (en && count != 32'hFFFF_FFFF) begin
      count <= count + 32'd1;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/sequencing control for the 6-stage pipeline.
// Load-use stalls, branch flushes, memory wait states.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned LOAD_BUBBLES = 1,
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned MEM_TIMEOUT  = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  idrr_rs,
  input  logic [4:0]  idrr_rt,
  input  logic        idrr_valid,
  input  logic [4:0]  rrex_rt,
  input  logic        rrex_memread,
  input  logic        ex_branch_taken,
  input  logic        exmem_memreq,
  input  logic        mem_ready,
  output logic        pc_write,
  output logic        ifid_write,
  output logic        idrr_write,
  output logic        rrex_bubble,
  output logic        ifid_flush,
  output logic        idrr_flush,
  output logic        pc_src_branch,
  output logic        pipe_freeze,
  output logic        mem_timeout,
  output logic [31:0] stall_count,
  output logic [31:0] flush_count
);

  hz_state_t          state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               tmo_q, tmo_d;

  logic ldhaz, memhaz, br;
  logic frozen, enter_mw, do_br, in_fl, do_ld;
  logic stall_en;

  // Hazards are masked in reset so outputs show plain RUN.
  always_comb begin
    ldhaz  = ~reset & rrex_memread & idrr_valid
           & (rrex_rt != 5'd0)
           & ((rrex_rt == idrr_rs) | (rrex_rt == idrr_rt));
    memhaz = ~reset & exmem_memreq & ~mem_ready;
    br     = ~reset & ex_branch_taken;
  end

  always_comb begin
    frozen   = (state_q == MEMWAIT) & ~mem_ready;
    enter_mw = ~frozen & memhaz;
    do_br    = ~frozen & ~memhaz & br;
    in_fl    = ~frozen & ~memhaz & ~br
             & (state_q == FLUSH);
    do_ld    = ~frozen & ~memhaz & ~br & ~in_fl
             & (ldhaz | (state_q == LDSTALL));
  end

  always_comb begin
    pc_write      = 1'b1;
    ifid_write    = 1'b1;
    idrr_write    = 1'b1;
    rrex_bubble   = 1'b0;
    ifid_flush    = 1'b0;
    idrr_flush    = 1'b0;
    pc_src_branch = 1'b0;
    pipe_freeze   = 1'b0;
    state_d       = state_q;
    cnt_d         = cnt_q;
    tmo_d         = tmo_q;
    unique case (1'b1)
      frozen: begin
        pipe_freeze = 1'b1;
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        idrr_write  = 1'b0;
        if (cnt_q <= CNT_W'(1)) tmo_d = 1'b1;
        if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
      end
      enter_mw: begin
        pipe_freeze = 1'b1;
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        idrr_write  = 1'b0;
        state_d     = MEMWAIT;
        cnt_d       = CNT_W'(MEM_TIMEOUT - 1);
        if (MEM_TIMEOUT == 1) tmo_d = 1'b1;
      end
      do_br: begin
        pc_src_branch = 1'b1;
        ifid_flush    = 1'b1;
        idrr_flush    = 1'b1;
        rrex_bubble   = 1'b1;
        if (FLUSH_CYCLES > 1) begin
          state_d = FLUSH;
          cnt_d   = CNT_W'(FLUSH_CYCLES - 2);
        end else begin
          state_d = RUN;
        end
      end
      in_fl: begin
        ifid_flush  = 1'b1;
        idrr_flush  = 1'b1;
        rrex_bubble = 1'b1;
        if (cnt_q == '0) state_d = RUN;
        else cnt_d = cnt_q - 1'b1;
      end
      do_ld: begin
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        idrr_write  = 1'b0;
        rrex_bubble = 1'b1;
        if (state_q == LDSTALL) begin
          if (cnt_q == '0) state_d = RUN;
          else cnt_d = cnt_q - 1'b1;
        end else if (LOAD_BUBBLES > 1) begin
          state_d = LDSTALL;
          cnt_d   = CNT_W'(LOAD_BUBBLES - 2);
        end else begin
          state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RUN;
      cnt_q   <= '0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
    end
  end

  assign mem_timeout = tmo_q;
  assign stall_en = ~pc_write | ~ifid_write
                  | ~idrr_write | pipe_freeze;

  sat_counter32 u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .en    (stall_en),
    .count (stall_count)
  );

  sat_counter32 u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .en    (ifid_flush),
    .count (flush_count)
  );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: default and
// deep-stall/short-timeout configurations side by side.
module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] idrr_rs, idrr_rt, rrex_rt;
  logic       idrr_valid, rrex_memread;
  logic       ex_branch_taken, exmem_memreq, mem_ready;

  logic a_pcw, a_ifw, a_idw, a_bub, a_iff, a_idf, a_psb, a_frz, a_tmo;
  logic b_pcw, b_ifw, b_idw, b_bub, b_iff, b_idf, b_psb, b_frz, b_tmo;
  logic [31:0] a_sc, a_fc, b_sc, b_fc;
  logic [8:0]  oa, ob;

  int n_chk = 0;
  int n_fail = 0;

  localparam logic [8:0] O_RUN = 9'b111_0000_00;
  localparam logic [8:0] O_LD  = 9'b000_1000_00;
  localparam logic [8:0] O_BR  = 9'b111_1111_00;
  localparam logic [8:0] O_FL  = 9'b111_1110_00;
  localparam logic [8:0] O_FR  = 9'b000_0000_10;
  localparam logic [8:0] O_FRT = 9'b000_0000_11;

  always #5 clk = ~clk;

  pipe_hazard_ctrl u_a (
    .clk(clk), .reset(reset),
    .idrr_rs(idrr_rs), .idrr_rt(idrr_rt),
    .idrr_valid(idrr_valid), .rrex_rt(rrex_rt),
    .rrex_memread(rrex_memread),
    .ex_branch_taken(ex_branch_taken),
    .exmem_memreq(exmem_memreq), .mem_ready(mem_ready),
    .pc_write(a_pcw), .ifid_write(a_ifw),
    .idrr_write(a_idw), .rrex_bubble(a_bub),
    .ifid_flush(a_iff), .idrr_flush(a_idf),
    .pc_src_branch(a_psb), .pipe_freeze(a_frz),
    .mem_timeout(a_tmo),
    .stall_count(a_sc), .flush_count(a_fc)
  );

  pipe_hazard_ctrl #(
    .LOAD_BUBBLES(3), .FLUSH_CYCLES(2), .MEM_TIMEOUT(8)
  ) u_b (
    .clk(clk), .reset(reset),
    .idrr_rs(idrr_rs), .idrr_rt(idrr_rt),
    .idrr_valid(idrr_valid), .rrex_rt(rrex_rt),
    .rrex_memread(rrex_memread),
    .ex_branch_taken(ex_branch_taken),
    .exmem_memreq(exmem_memreq), .mem_ready(mem_ready),
    .pc_write(b_pcw), .ifid_write(b_ifw),
    .idrr_write(b_idw), .rrex_bubble(b_bub),
    .ifid_flush(b_iff), .idrr_flush(b_idf),
    .pc_src_branch(b_psb), .pipe_freeze(b_frz),
    .mem_timeout(b_tmo),
    .stall_count(b_sc), .flush_count(b_fc)
  );

  assign oa = {a_pcw, a_ifw, a_idw, a_bub, a_iff,
               a_idf, a_psb, a_frz, a_tmo};
  assign ob = {b_pcw, b_ifw, b_idw, b_bub, b_iff,
               b_idf, b_psb, b_frz, b_tmo};

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    idrr_rs = 5'd0; idrr_rt = 5'd0; rrex_rt = 5'd0;
    idrr_valid = 1'b0; rrex_memread = 1'b0;
    ex_branch_taken = 1'b0;
    exmem_memreq = 1'b0; mem_ready = 1'b0;
  endtask

  task automatic load_use();
    rrex_memread = 1'b1; rrex_rt = 5'd5;
    idrr_rs = 5'd5; idrr_valid = 1'b1;
  endtask

  initial begin
    reset = 1'b1;
    clear_in();
    #2;
    check("rst_out_a", 32'(oa), 32'(O_RUN));
    check("rst_out_b", 32'(ob), 32'(O_RUN));
    check("rst_sc_a", a_sc, 32'd0);
    check("rst_fc_b", b_fc, 32'd0);
    tick();
    reset = 1'b0;
    tick();

    // load-use on r5
    load_use();
    #1;
    check("ld1_a", 32'(oa), 32'(O_LD));
    check("ld1_b", 32'(ob), 32'(O_LD));
    tick();
    clear_in();
    #1;
    check("ld2_a", 32'(oa), 32'(O_RUN));
    check("ld2_b", 32'(ob), 32'(O_LD));
    tick();
    check("ld3_a", 32'(oa), 32'(O_RUN));
    check("ld3_b", 32'(ob), 32'(O_LD));
    tick();
    check("ld_end_b", 32'(ob), 32'(O_RUN));
    check("ld_sc_a", a_sc, 32'd1);
    check("ld_sc_b", b_sc, 32'd3);

    // r0 and invalid RR never stall
    rrex_memread = 1'b1; idrr_valid = 1'b1;
    #1;
    check("r0_a", 32'(oa), 32'(O_RUN));
    check("r0_b", 32'(ob), 32'(O_RUN));
    rrex_rt = 5'd9; idrr_rt = 5'd9; idrr_valid = 1'b0;
    #1;
    check("inval_b", 32'(ob), 32'(O_RUN));
    tick();
    clear_in();
    check("r0_sc_a", a_sc, 32'd1);

    // branch coincident with load-use
    load_use();
    ex_branch_taken = 1'b1;
    #1;
    check("br_a", 32'(oa), 32'(O_BR));
    check("br_b", 32'(ob), 32'(O_BR));
    tick();
    clear_in();
    #1;
    check("br2_a", 32'(oa), 32'(O_RUN));
    check("br2_b", 32'(ob), 32'(O_FL));
    tick();
    check("br3_b", 32'(ob), 32'(O_RUN));
    check("br_fc_a", a_fc, 32'd1);
    check("br_fc_b", b_fc, 32'd2);
    check("br_sc_b", b_sc, 32'd3);

    // four wait states then ready
    exmem_memreq = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check($sformatf("mw%0d_a", i), 32'(oa), 32'(O_FR));
      check($sformatf("mw%0d_b", i), 32'(ob), 32'(O_FR));
      tick();
    end
    mem_ready = 1'b1;
    #1;
    check("mw_rdy_a", 32'(oa), 32'(O_RUN));
    check("mw_rdy_b", 32'(ob), 32'(O_RUN));
    tick();
    clear_in();
    check("mw_sc_a", a_sc, 32'd5);
    check("mw_sc_b", b_sc, 32'd7);

    // timeout after 8 frozen cycles
    exmem_memreq = 1'b1;
    for (int i = 0; i < 7; i++) tick();
    check("tmo7_b", 32'(ob), 32'(O_FR));
    tick();
    check("tmo8_b", 32'(ob), 32'(O_FRT));
    tick(); tick(); tick();
    check("tmo_hold_b", 32'(ob), 32'(O_FRT));
    check("tmo_none_a", 32'(oa), 32'(O_FR));
    #1;
    reset = 1'b1;
    #1;
    check("tmo_rst_b", 32'(ob), 32'(O_RUN));
    check("tmo_rst_a", 32'(oa), 32'(O_RUN));
    check("tmo_rst_sc_b", b_sc, 32'd0);
    clear_in();
    tick();
    reset = 1'b0;
    tick();

    // reset during second bubble
    load_use();
    tick();
    clear_in();
    #1;
    check("ldr2_b", 32'(ob), 32'(O_LD));
    check("ldr2_sc_b", b_sc, 32'd1);
    reset = 1'b1;
    #1;
    check("ldr_rst_b", 32'(ob), 32'(O_RUN));
    check("ldr_rst_sc_b", b_sc, 32'd0);
    tick();
    reset = 1'b0;
    tick();
    check("ldr_run_b", 32'(ob), 32'(O_RUN));
    check("ldr_run_sc_b", b_sc, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Hazard and sequencing controller for the 6-stage pipeline (IF, ID, RR, EX, MEM, WB).
- Drives the hold, flush and bubble controls of the IF/ID, ID/RR and RR/EX pipeline registers and the PC.
- Handles three hazard classes: load-use stalls, taken-branch flushes, and data-memory wait states.
- Keeps saturating performance counters for stall and flush cycles.

Parameters:
- LOAD_BUBBLES, 1, bubbles inserted per load-use hazard (1..3).
- FLUSH_CYCLES, 1, cycles flush is asserted after a taken branch (1..3).
- MEM_TIMEOUT, 255, max MEMWAIT cycles before mem_timeout is raised (1..255).

Ports:
- clk  in  1  pipeline clock
- reset  in  1  asynchronous, active-high reset
- idrr_rs  in  5  rs of instruction in RR stage
- idrr_rt  in  5  rt of instruction in RR stage
- idrr_valid  in  1  RR stage holds a real instruction
- rrex_rt  in  5  destination (rt) of instruction in EX
- rrex_memread  in  1  EX instruction is a load
- ex_branch_taken  in  1  branch resolved taken in EX this cycle
- exmem_memreq  in  1  MEM-stage read or write in progress
- mem_ready  in  1  data memory completes access this cycle
- pc_write  out  1  PC update enable
- ifid_write  out  1  IF/ID load enable
- idrr_write  out  1  ID/RR load enable
- rrex_bubble  out  1  RR/EX loads all-zero controls (regwrite..branch = 0)
- ifid_flush  out  1  clear IF/ID
- idrr_flush  out  1  clear ID/RR
- pc_src_branch  out  1  select branch target for PC
- pipe_freeze  out  1  hold RR/EX, EX/MEM, MEM/WB
- mem_timeout  out  1  sticky memory timeout error
- stall_count  out  32  saturating count of stall/bubble cycles
- flush_count  out  32  saturating count of flush cycles

Behaviour:
- States: RUN, LDSTALL, FLUSH, MEMWAIT. State is encoded 2-bit; a down-counter cnt is 8-bit.
- Reset (async): state=RUN, cnt=0, mem_timeout=0, counters=0.
- Outputs in reset are decode of RUN with no hazard: pc_write=ifid_write=idrr_write=1; all others 0.
- Outputs are a Mealy decode of state plus current inputs; state and counters update on posedge clk.
- Hazard detect:
  - ldhaz = rrex_memread & idrr_valid & rrex_rt!=0 & (rrex_rt==idrr_rs | rrex_rt==idrr_rt).
  - memhaz = exmem_memreq & ~mem_ready.
- Priority each cycle: memhaz > ex_branch_taken > ldhaz.
- RUN:
  - On memhaz: pipe_freeze=1, pc/ifid/idrr write=0. Next state MEMWAIT, cnt=MEM_TIMEOUT-1.
  - Else on ex_branch_taken: pc_src_branch=1, ifid_flush=idrr_flush=rrex_bubble=1, pc_write=1. If FLUSH_CYCLES>1, next state FLUSH with cnt=FLUSH_CYCLES-2.
  - Else on ldhaz: pc/ifid/idrr write=0, rrex_bubble=1. If LOAD_BUBBLES>1, next state LDSTALL with cnt=LOAD_BUBBLES-2.
- LDSTALL: same outputs as the ldhaz cycle. When cnt==0, go to RUN; otherwise decrement cnt. Higher-priority events preempt exactly as in RUN.
- FLUSH: ifid_flush=idrr_flush=rrex_bubble=1, pc_write=1, pc_src_branch=0. When cnt==0, go to RUN.
- MEMWAIT:
  - Freeze outputs are held while ~mem_ready.
  - When mem_ready=1, freeze drops in that same cycle and the next state is RUN.
  - If cnt reaches 0 with ~mem_ready, set mem_timeout=1 (sticky until reset) and stay in MEMWAIT.
  - ex_branch_taken and ldhaz are ignored while frozen, since the EX instruction is held and they are re-evaluated after release.
- Counters:
  - stall_count increments when any write enable is 0 or pipe_freeze=1.
  - flush_count increments when ifid_flush=1.
  - Both saturate at 32'hFFFF_FFFF.
- Register 0 never causes a hazard.
- Branch and load-use in the same cycle: flush wins, and the load-use instruction is discarded.
- Reset asserted mid-stall: immediate return to RUN, with outputs as in the reset state.

Decomposition:
- Shared package `pipe_ctrl_pkg`: state enum constants (RUN=0, LDSTALL=1, FLUSH=2, MEMWAIT=3) and the bubble control-zero constant.
- One sub-module, `sat_counter32` (enable, saturate), instantiated twice for the perf counters.

Test Plan:
- Load to r5 in EX (rrex_memread=1, rrex_rt=5) with RR instruction rs=5 -> 1 cycle of pc_write=0, rrex_bubble=1; stall_count=1; back to RUN.
- Same with LOAD_BUBBLES=3 -> 3 consecutive bubble cycles; stall_count=3. Same with rrex_rt=0 -> no stall.
- ex_branch_taken=1 coincident with ldhaz -> pc_src_branch=1, ifid_flush=idrr_flush=rrex_bubble=1 for 1 cycle; flush_count=1; no LDSTALL entry.
- exmem_memreq=1, mem_ready=0 for 4 cycles then 1 -> pipe_freeze=1 for 4 cycles and 0 on the ready cycle; stall_count=4.
- MEM_TIMEOUT=8, mem_ready held 0 -> mem_timeout=1 after 8 frozen cycles and stays 1; async reset clears it without a clock edge.
- Reset asserted during LDSTALL (LOAD_BUBBLES=3, 2nd bubble) -> outputs return to the reset state immediately; counters=0.
